// File: rtl/vm_pkg.sv
// Shared types for the vending machine core and its change dispenser.
package vm_pkg;

  // Outcome reported by the vending core.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_VEND_OK = 2'b01,
    ST_REFUND  = 2'b10,
    ST_ERROR   = 2'b11
  } vm_status_t;

  // Coin ejector codes.
  typedef enum logic [1:0] {
    C1  = 2'b00,
    C5  = 2'b01,
    C10 = 2'b10,
    C25 = 2'b11
  } coin_t;

  // Unit value of each coin code.
  localparam logic [4:0] COIN_V1  = 5'd1;
  localparam logic [4:0] COIN_V5  = 5'd5;
  localparam logic [4:0] COIN_V10 = 5'd10;
  localparam logic [4:0] COIN_V25 = 5'd25;

  // Dispenser controller states.
  typedef enum logic [2:0] {
    DS_IDLE   = 3'd0,
    DS_VEND   = 3'd1,
    DS_CHANGE = 3'd2,
    DS_DONE   = 3'd3,
    DS_FAULT  = 3'd4
  } disp_state_t;

endpackage

// File: rtl/vm_coin_select.sv
// Greedy coin selector: largest denomination not exceeding the amount owed.
// With an amount of zero it reports C1; the caller only uses it while
// change is still owed.
module vm_coin_select
  import vm_pkg::*;
(
  input  logic [7:0] remaining_i,
  output coin_t      coin_o,
  output logic [4:0] value_o
);

  // Pick the biggest coin that still fits into the owed amount.
  always_comb begin
    coin_o  = C1;
    value_o = COIN_V1;
    if (remaining_i >= {3'b000, COIN_V25}) begin
      coin_o  = C25;
      value_o = COIN_V25;
    end else if (remaining_i >= {3'b000, COIN_V10}) begin
      coin_o  = C10;
      value_o = COIN_V10;
    end else if (remaining_i >= {3'b000, COIN_V5}) begin
      coin_o  = C5;
      value_o = COIN_V5;
    end
  end

endmodule

// File: rtl/vm_change_dispenser.sv
// Change dispenser: ejects the vended product, then pays the balance out
// one greedy coin per handshake, with a stall watchdog that parks the
// block in a sticky FAULT state.
//
// Handshakes (product and coin ejectors): a transfer happens on a rising
// edge where valid and ready are both high. While valid is high the payload
// (prod_id / coin_out) is held stable until that transfer; ready while valid
// is low has no effect.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int COIN_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  status,
  input  logic [2:0]  product,
  input  logic [7:0]  balance,
  input  logic        prod_ready,
  input  logic        coin_ready,
  output logic        prod_valid,
  output logic [2:0]  prod_id,
  output logic        coin_valid,
  output logic [1:0]  coin_out,
  output logic [7:0]  remaining,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output disp_state_t dbg_state
);

  localparam int TO_W = $clog2(COIN_TIMEOUT + 1);
  // Last stalled cycle before the watchdog fires: the counter would reach
  // COIN_TIMEOUT on this edge, so the block goes straight to FAULT.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(COIN_TIMEOUT - 1);

  disp_state_t     state_q, state_d;
  logic [2:0]      pid_q, pid_d;
  logic [7:0]      rem_q, rem_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            armed_q, armed_d;

  coin_t           sel_coin;
  logic [4:0]      sel_value;
  vm_status_t      st;

  assign st = vm_status_t'(status);

  vm_coin_select u_coin_select (
    .remaining_i (rem_q),
    .coin_o      (sel_coin),
    .value_o     (sel_value)
  );

  // State and datapath registers; reset abandons any payout in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DS_IDLE;
      pid_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d    = state_q;
    pid_d      = pid_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    armed_d    = armed_q;
    prod_valid = 1'b0;
    coin_valid = 1'b0;
    done       = 1'b0;

    // Seeing the core idle re-arms the trigger, in every state.
    if (st == ST_IDLE) armed_d = 1'b1;

    case (state_q)
      DS_IDLE: begin
        if (armed_q && (st == ST_VEND_OK || st == ST_REFUND)) begin
          armed_d = 1'b0;
          pid_d   = product;
          rem_d   = balance;
          cnt_d   = '0;
          if (st == ST_VEND_OK)     state_d = DS_VEND;
          else if (balance != 8'd0) state_d = DS_CHANGE;
          else                      state_d = DS_DONE;
        end
      end

      DS_VEND: begin
        prod_valid = 1'b1;
        if (prod_ready) begin
          cnt_d   = '0;
          state_d = (rem_q != 8'd0) ? DS_CHANGE : DS_DONE;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          state_d = DS_FAULT;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      DS_CHANGE: begin
        coin_valid = 1'b1;
        if (coin_ready) begin
          // Greedy choice never exceeds rem_q, so this cannot underflow.
          rem_d = rem_q - {3'b000, sel_value};
          cnt_d = '0;
          if (rem_d == 8'd0) state_d = DS_DONE;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          state_d = DS_FAULT;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      DS_DONE: begin
        done    = 1'b1;
        state_d = DS_IDLE;
      end

      DS_FAULT: begin
        // Parked until reset; remaining keeps the unpaid amount.
      end

      default: state_d = DS_IDLE;
    endcase
  end

  // Status flags and payload outputs derived from registered state.
  assign busy      = (state_q == DS_VEND) || (state_q == DS_CHANGE) || (state_q == DS_DONE);
  assign fault     = (state_q == DS_FAULT);
  assign coin_out  = (state_q == DS_CHANGE) ? sel_coin : C1;
  assign prod_id   = pid_q;
  assign remaining = rem_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Bench for vm_change_dispenser: directed scenarios followed by random
// transactions checked against a transaction-level payout model.
module tb_vm_change_dispenser;
  import vm_pkg::*;

  localparam int P_PROD = 0;
  localparam int P_COIN = 1;
  localparam int P_DONE = 2;
  localparam int P_END  = 3;

  logic        clk;
  logic        rst;
  logic [1:0]  status;
  logic [2:0]  product;
  logic [7:0]  balance;
  logic        prod_ready;
  logic        coin_ready;
  logic        prod_valid;
  logic [2:0]  prod_id;
  logic        coin_valid;
  logic [1:0]  coin_out;
  logic [7:0]  remaining;
  logic        busy;
  logic        done;
  logic        fault;
  disp_state_t dbg_state;

  int n_asserts = 0;
  int n_fail    = 0;

  vm_change_dispenser #(.COIN_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .status     (status),
    .product    (product),
    .balance    (balance),
    .prod_ready (prod_ready),
    .coin_ready (coin_ready),
    .prod_valid (prod_valid),
    .prod_id    (prod_id),
    .coin_valid (coin_valid),
    .coin_out   (coin_out),
    .remaining  (remaining),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int coin_units(input logic [1:0] code);
    case (code)
      2'b00:   return 1;
      2'b01:   return 5;
      2'b10:   return 10;
      default: return 25;
    endcase
  endfunction

  // Expected coin sequence for an amount: repeatedly take the largest coin that fits.
  function automatic void build_coins(input int amount, output logic [1:0] q[$]);
    int r;
    q.delete();
    r = amount;
    while (r > 0) begin
      if (r >= 25)      begin q.push_back(2'b11); r -= 25; end
      else if (r >= 10) begin q.push_back(2'b10); r -= 10; end
      else if (r >= 5)  begin q.push_back(2'b01); r -= 5;  end
      else              begin q.push_back(2'b00); r -= 1;  end
    end
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_pv"},    32'(prod_valid), 32'd0);
    check({tag, "_cv"},    32'(coin_valid), 32'd0);
    check({tag, "_rem"},   32'(remaining), 32'd0);
  endtask

  // One full transaction. mode: 0 readies always high, 1 toggling, 2 random.
  task automatic run_txn(input logic [1:0] st, input logic [2:0] prod, input logic [7:0] bal,
                         input int mode, input bit chk_len, input int exp_len);
    logic [1:0] exp_q[$];
    int rem_m, phase, cyc, stall_run;
    bit rdy;
    @(negedge clk);
    status = 2'b00; prod_ready = 1'b0; coin_ready = 1'b0;
    @(negedge clk);
    status = st; product = prod; balance = bal;
    build_coins(int'(bal), exp_q);
    rem_m = int'(bal);
    phase = (st == 2'b01) ? P_PROD : ((bal != 8'd0) ? P_COIN : P_DONE);
    cyc = 0; stall_run = 0;
    while (phase != P_END && cyc < 300) begin
      @(negedge clk);
      cyc++;
      // Trigger inputs wander mid-transaction; status stays held.
      product = 3'($urandom);
      balance = 8'($urandom);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = cyc[0];
        default: rdy = (stall_run >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      check("fault_clear", 32'(fault), 32'd0);
      case (phase)
        P_PROD: begin
          check("prod_valid", 32'(prod_valid), 32'd1);
          check("prod_id",    32'(prod_id), 32'(prod));
          check("cv_in_prod", 32'(coin_valid), 32'd0);
          check("busy_prod",  32'(busy), 32'd1);
          prod_ready = rdy;
          coin_ready = 1'($urandom);
          if (rdy) begin
            stall_run = 0;
            phase = (exp_q.size() != 0) ? P_COIN : P_DONE;
          end else stall_run++;
        end
        P_COIN: begin
          check("coin_valid", 32'(coin_valid), 32'd1);
          check("pv_in_coin", 32'(prod_valid), 32'd0);
          check("coin_out",   32'(coin_out), 32'(exp_q[0]));
          check("remaining",  32'(remaining), 32'(rem_m));
          check("done_early", 32'(done), 32'd0);
          coin_ready = rdy;
          prod_ready = 1'($urandom);
          if (rdy) begin
            rem_m -= coin_units(exp_q[0]);
            void'(exp_q.pop_front());
            stall_run = 0;
            phase = (exp_q.size() != 0) ? P_COIN : P_DONE;
          end else stall_run++;
        end
        default: begin
          check("done_pulse", 32'(done), 32'd1);
          check("busy_done",  32'(busy), 32'd1);
          check("cv_in_done", 32'(coin_valid), 32'd0);
          check("rem_done",   32'(remaining), 32'd0);
          prod_ready = 1'($urandom);
          coin_ready = 1'($urandom);
          phase = P_END;
        end
      endcase
    end
    check("txn_finished", 32'(phase), 32'(P_END));
    @(negedge clk);
    check_quiet("after_txn");
    if (chk_len) check("txn_len", 32'(cyc + 1), 32'(exp_len));
    // Status still held at the event code: must not retrigger.
    repeat (3) begin
      @(negedge clk);
      check("no_retrigger", 32'(busy), 32'd0);
    end
    status = 2'b00;
  endtask

  initial begin
    rst = 1'b0; status = 2'b00; product = '0; balance = '0;
    prod_ready = 1'b0; coin_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_fault",   32'(fault), 32'd0);
    check("reset_prod_id", 32'(prod_id), 32'd0);
    check("reset_coin",    32'(coin_out), 32'd0);
    rst = 1'b1;

    // Vend with change 25+10+5, readies always high
    run_txn(2'b01, 3'd3, 8'd40, 0, 1'b1, 6);
    // Refund 7 with toggling readies: 5,1,1
    run_txn(2'b10, 3'd0, 8'd7, 1, 1'b0, 0);
    // Vend with no change: product then straight to done
    run_txn(2'b01, 3'd5, 8'd0, 0, 1'b1, 3);
    // Refund of zero: just the done pulse
    run_txn(2'b10, 3'd1, 8'd0, 0, 1'b1, 2);

    // Error status is ignored
    @(negedge clk); status = 2'b00;
    @(negedge clk); status = 2'b11; balance = 8'd50;
    repeat (4) begin
      @(negedge clk);
      check_quiet("err_status");
    end
    status = 2'b00;

    // Reset in the middle of a payout
    @(negedge clk); status = 2'b00; coin_ready = 1'b1;
    @(negedge clk); status = 2'b10; balance = 8'd30;
    @(negedge clk);
    check("rstmid_coin0", 32'(coin_out), 32'd3);
    check("rstmid_rem0",  32'(remaining), 32'd30);
    @(negedge clk);
    check("rstmid_coin1", 32'(coin_out), 32'd1);
    check("rstmid_rem1",  32'(remaining), 32'd5);
    rst = 1'b0; coin_ready = 1'b0;
    @(negedge clk);
    check_quiet("rstmid_reset");
    check("rstmid_coin", 32'(coin_out), 32'd0);
    check("rstmid_pid",  32'(prod_id), 32'd0);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_quiet("rstmid_noarm");
    end
    status = 2'b00;

    // Coin ejector stuck: watchdog fault after 4 stalled cycles
    @(negedge clk); status = 2'b00; coin_ready = 1'b0;
    @(negedge clk); status = 2'b10; balance = 8'd255;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_cv",    32'(coin_valid), 32'd1);
      check("stall_coin",  32'(coin_out), 32'd3);
      check("stall_rem",   32'(remaining), 32'd255);
      check("stall_fault", 32'(fault), 32'd0);
    end
    @(negedge clk);
    check("fault_set",  32'(fault), 32'd1);
    check("fault_cv",   32'(coin_valid), 32'd0);
    check("fault_rem",  32'(remaining), 32'd255);
    check("fault_busy", 32'(busy), 32'd0);
    status = 2'b00; coin_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fault_sticky", 32'(fault), 32'd1);
      check("fault_pv",     32'(prod_valid), 32'd0);
      status = (i % 2 == 0) ? 2'b01 : 2'b00;
    end
    rst = 1'b0;
    @(negedge clk);
    check("fault_reset", 32'(fault), 32'd0);
    check_quiet("fault_reset");
    rst = 1'b1; status = 2'b00;

    // Random transactions against the payout model
    for (int t = 0; t < 20; t++) begin
      run_txn(2'($urandom_range(1, 2)), 3'($urandom_range(0, 7)),
              8'($urandom_range(0, 255)), $urandom_range(0, 2), 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
